motor_pwm_ramp: RTL and testbench



---
 rtl/motor_pwm_ramp.sv | 124 ++++++++++++
 tb/tb_motor_pwm_ramp.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/motor_pwm_ramp.sv
// Soft-start / soft-stop PWM driver: turns the supervisory arm pulse (f) and
// run level (g) into a ramped duty value and a registered PWM pad output.
module motor_pwm_ramp #(
  parameter int PWM_BITS  = 8,
  parameter int RAMP_STEP = 64,
  parameter int RAMP_DIV  = 4,
  parameter int MAX_DUTY  = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                f,
  input  logic                g,
  output logic                pwm,
  output logic [PWM_BITS-1:0] duty,
  output logic                running,
  output logic                at_speed,
  output logic [2:0]          o_dbg_state
);

  localparam int TICK_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [TICK_W-1:0]   TICK_LAST = TICK_W'(RAMP_DIV - 1);
  localparam logic [PWM_BITS:0]   STEP_W    = (PWM_BITS + 1)'(RAMP_STEP);
  localparam logic [PWM_BITS:0]   MAX_W     = (PWM_BITS + 1)'(MAX_DUTY);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ARMED     = 3'd1,
    S_RAMP_UP   = 3'd2,
    S_RUN       = 3'd3,
    S_RAMP_DOWN = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [PWM_BITS-1:0] r_duty;
  logic [PWM_BITS-1:0] w_duty_nxt;
  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic [TICK_W-1:0]   r_tick_cnt;
  logic                r_pwm;
  logic                w_in_ramp;
  logic                w_tick;
  logic [PWM_BITS:0]   w_up_sum;
  logic [PWM_BITS:0]   w_up_sat;
  logic [PWM_BITS:0]   w_dn_diff;
  logic [PWM_BITS-1:0] w_duty_up;
  logic [PWM_BITS-1:0] w_duty_dn;

  assign w_in_ramp = (r_state == S_RAMP_UP) || (r_state == S_RAMP_DOWN);
  assign w_tick    = w_in_ramp && (r_tick_cnt == TICK_LAST);

  // Ramp arithmetic is one bit wider than duty so neither direction can wrap.
  assign w_up_sum  = {1'b0, r_duty} + STEP_W;
  assign w_up_sat  = (w_up_sum >= MAX_W) ? MAX_W : w_up_sum;
  assign w_duty_up = w_up_sat[PWM_BITS-1:0];
  assign w_dn_diff = {1'b0, r_duty} - STEP_W;
  assign w_duty_dn = ({1'b0, r_duty} > STEP_W) ? w_dn_diff[PWM_BITS-1:0] : '0;

  always_comb begin
    w_state_nxt = r_state;
    w_duty_nxt  = r_duty;
    case (r_state)
      S_IDLE: begin
        w_duty_nxt = '0;
        if (f) w_state_nxt = S_ARMED;
      end
      S_ARMED: begin
        w_duty_nxt = '0;
        if (g) w_state_nxt = S_RAMP_UP;
      end
      // A direction change beats a tick landing on the same edge.
      S_RAMP_UP: begin
        if (!g) begin
          w_state_nxt = S_RAMP_DOWN;
        end else if (w_tick) begin
          w_duty_nxt = w_duty_up;
          if (w_up_sat == MAX_W) w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_duty_nxt = MAX_W[PWM_BITS-1:0];
        if (!g) w_state_nxt = S_RAMP_DOWN;
      end
      S_RAMP_DOWN: begin
        if (g) begin
          w_state_nxt = S_RAMP_UP;
        end else if (w_tick) begin
          w_duty_nxt = w_duty_dn;
          if (w_duty_dn == '0) w_state_nxt = S_ARMED;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_duty_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_duty     <= '0;
      r_tick_cnt <= '0;
      r_pwm_cnt  <= '0;
      r_pwm      <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_duty    <= w_duty_nxt;
      r_pwm_cnt <= r_pwm_cnt + 1'b1;
      r_pwm     <= (r_pwm_cnt < r_duty);
      if ((w_state_nxt != r_state) || !w_in_ramp || w_tick) begin
        r_tick_cnt <= '0;
      end else begin
        r_tick_cnt <= r_tick_cnt + TICK_W'(1);
      end
    end
  end

  assign pwm         = r_pwm;
  assign duty        = r_duty;
  assign running     = w_in_ramp || (r_state == S_RUN);
  assign at_speed    = (r_state == S_RUN);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_motor_pwm_ramp.sv
// Directed bench for motor_pwm_ramp: default-parameter instance plus a
// saturation instance (step 100, max 250) sharing clock and reset.
module tb_motor_pwm_ramp;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ARMED = 3'd1;
  localparam logic [2:0] ST_UP    = 3'd2;
  localparam logic [2:0] ST_RUN   = 3'd3;
  localparam logic [2:0] ST_DOWN  = 3'd4;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic       f1 = 1'b0, g1 = 1'b0;
  logic       f2 = 1'b0, g2 = 1'b0;
  logic       pwm1, running1, at_speed1;
  logic       pwm2, running2, at_speed2;
  logic [7:0] duty1, duty2;
  logic [2:0] st1, st2;

  int         n_cmp = 0;
  int         n_err = 0;
  int         highs;
  logic [7:0] exp_q[$];

  motor_pwm_ramp u_dut (
    .clk(clk), .reset(reset), .f(f1), .g(g1),
    .pwm(pwm1), .duty(duty1), .running(running1), .at_speed(at_speed1),
    .o_dbg_state(st1)
  );

  motor_pwm_ramp #(.PWM_BITS(8), .RAMP_STEP(100), .RAMP_DIV(4), .MAX_DUTY(250)) u_sat (
    .clk(clk), .reset(reset), .f(f2), .g(g2),
    .pwm(pwm2), .duty(duty2), .running(running2), .at_speed(at_speed2),
    .o_dbg_state(st2)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] duty_of(input bit sel);
    return sel ? duty2 : duty1;
  endfunction

  // Drains exp_q: duty must hold for div-1 edges, then move to the next entry.
  task automatic ramp_seq(input string tag, input bit sel, input int div, input logic [7:0] start);
    logic [7:0] prev;
    logic [7:0] e;
    prev = start;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      step(div - 1);
      check_val({tag, "_hold"}, duty_of(sel), prev);
      step(1);
      check_val(tag, duty_of(sel), e);
      prev = e;
    end
  endtask

  task automatic count_pwm(input int n, output int h);
    h = 0;
    for (int i = 0; i < n; i++) begin
      step(1);
      if (pwm1) h++;
    end
  endtask

  initial begin
    #1 reset = 1'b1;
    #1;
    check_val("rst_state", st1, ST_IDLE);
    check_val("rst_duty", duty1, 0);
    check_val("rst_pwm", pwm1, 0);
    check_val("rst_running", running1, 0);
    check_val("rst_at_speed", at_speed1, 0);
    step(2);
    reset = 1'b0;

    // g alone never leaves IDLE
    g1 = 1'b1;
    count_pwm(50, highs);
    check_val("idle_pwm_highs", highs, 0);
    check_val("idle_state", st1, ST_IDLE);
    check_val("idle_duty", duty1, 0);
    check_val("idle_running", running1, 0);

    // arm and ramp up
    g1 = 1'b0;
    f1 = 1'b1;
    step(1);
    f1 = 1'b0;
    check_val("arm_state", st1, ST_ARMED);
    g1 = 1'b1;
    step(1);
    check_val("up_entry_state", st1, ST_UP);
    check_val("up_entry_running", running1, 1);
    check_val("up_entry_duty", duty1, 0);
    exp_q.push_back(8'd64);
    exp_q.push_back(8'd128);
    exp_q.push_back(8'd192);
    ramp_seq("up", 1'b0, 4, 8'd0);
    step(3);
    check_val("at_speed_before16", at_speed1, 0);
    step(1);
    check_val("up_final_duty", duty1, 255);
    check_val("at_speed_at16", at_speed1, 1);
    check_val("run_state", st1, ST_RUN);

    f1 = 1'b1;
    step(1);
    f1 = 1'b0;
    check_val("run_f_ignored", st1, ST_RUN);
    count_pwm(256, highs);
    check_val("run_pwm_highs", highs, 255);

    // soft stop
    g1 = 1'b0;
    step(1);
    check_val("down_entry_state", st1, ST_DOWN);
    exp_q.push_back(8'd191);
    exp_q.push_back(8'd127);
    exp_q.push_back(8'd63);
    exp_q.push_back(8'd0);
    ramp_seq("down", 1'b0, 4, 8'd255);
    check_val("stop_state", st1, ST_ARMED);
    check_val("stop_running", running1, 0);
    step(2);
    count_pwm(300, highs);
    check_val("stop_pwm_highs", highs, 0);

    // reversal: up to 128, one down tick, back up
    g1 = 1'b1;
    step(1);
    exp_q.push_back(8'd64);
    exp_q.push_back(8'd128);
    ramp_seq("rev_up", 1'b0, 4, 8'd0);
    g1 = 1'b0;
    step(1);
    check_val("rev_down_state", st1, ST_DOWN);
    check_val("rev_down_duty", duty1, 128);
    exp_q.push_back(8'd64);
    ramp_seq("rev_down", 1'b0, 4, 8'd128);
    g1 = 1'b1;
    step(1);
    check_val("rev_reup_state", st1, ST_UP);
    check_val("rev_reup_duty", duty1, 64);
    exp_q.push_back(8'd128);
    exp_q.push_back(8'd192);
    exp_q.push_back(8'd255);
    ramp_seq("rev_reup", 1'b0, 4, 8'd64);
    check_val("rev_run_state", st1, ST_RUN);

    // direction change landing on a tick edge
    g1 = 1'b0;
    step(1);
    exp_q.push_back(8'd191);
    ramp_seq("tick_dn", 1'b0, 4, 8'd255);
    g1 = 1'b1;
    step(1);
    check_val("tick_up_state", st1, ST_UP);
    step(3);
    g1 = 1'b0;
    step(1);
    check_val("tickedge_up2dn_state", st1, ST_DOWN);
    check_val("tickedge_up2dn_duty", duty1, 191);
    step(3);
    g1 = 1'b1;
    step(1);
    check_val("tickedge_dn2up_state", st1, ST_UP);
    check_val("tickedge_dn2up_duty", duty1, 191);
    exp_q.push_back(8'd255);
    ramp_seq("tick_resume", 1'b0, 4, 8'd191);
    check_val("tick_resume_state", st1, ST_RUN);

    // async reset mid-ramp at duty 192
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    g1 = 1'b0;
    f1 = 1'b1;
    step(1);
    f1 = 1'b0;
    g1 = 1'b1;
    step(1);
    exp_q.push_back(8'd64);
    exp_q.push_back(8'd128);
    exp_q.push_back(8'd192);
    ramp_seq("pre_areset", 1'b0, 4, 8'd0);
    #2 reset = 1'b1;
    #1;
    check_val("areset_duty", duty1, 0);
    check_val("areset_pwm", pwm1, 0);
    check_val("areset_running", running1, 0);
    check_val("areset_state", st1, ST_IDLE);
    step(1);
    reset = 1'b0;
    step(10);
    check_val("post_reset_idle", st1, ST_IDLE);
    check_val("post_reset_duty", duty1, 0);
    f1 = 1'b1;
    step(1);
    f1 = 1'b0;
    check_val("rearm_state", st1, ST_ARMED);
    step(1);
    check_val("rearm_up_state", st1, ST_UP);
    g1 = 1'b0;

    // saturation instance
    f2 = 1'b1;
    step(1);
    f2 = 1'b0;
    check_val("sat_arm_state", st2, ST_ARMED);
    g2 = 1'b1;
    step(1);
    exp_q.push_back(8'd100);
    exp_q.push_back(8'd200);
    exp_q.push_back(8'd250);
    ramp_seq("sat_up", 1'b1, 4, 8'd0);
    check_val("sat_run_state", st2, ST_RUN);
    check_val("sat_at_speed", at_speed2, 1);
    g2 = 1'b0;
    step(1);
    exp_q.push_back(8'd150);
    exp_q.push_back(8'd50);
    exp_q.push_back(8'd0);
    ramp_seq("sat_down", 1'b1, 4, 8'd250);
    check_val("sat_stop_state", st2, ST_ARMED);
    check_val("sat_stop_running", running2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
